// File: rtl/fetch_multiport_if.sv
// Scheduler/decode-facing bundle of the multiport fetch block: warp PC table,
// per-port grants and back-pressure, per-warp flush, fetched-instruction
// outputs and the file-IO program-load port.
interface fetch_multiport_if #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int IMEM_AW   = 10
);
  logic [NUM_WARPS*ADDR_W-1:0]    pc_all;
  logic [NUM_WARPS-1:0]           pc_valid;
  logic [NUM_PORTS*NUM_WARPS-1:0] grant;
  logic [NUM_PORTS-1:0]           in_ready;
  logic [NUM_WARPS-1:0]           flush;
  logic [NUM_PORTS-1:0]           out_valid;
  logic [NUM_PORTS-1:0]           out_ready;
  logic [NUM_PORTS*NUM_WARPS-1:0] out_warp;
  logic [NUM_PORTS*ADDR_W-1:0]    out_pc;
  logic [NUM_PORTS*32-1:0]        out_instr;
  logic                           fio_wen;
  logic [IMEM_AW-1:0]             fio_addr;
  logic [31:0]                    fio_din;
  logic [31:0]                    fio_dout;
  logic                           grant_err;

  // Scheduler / decode / loader side
  modport master (
    output pc_all, pc_valid, grant, flush, out_ready, fio_wen, fio_addr, fio_din,
    input  in_ready, out_valid, out_warp, out_pc, out_instr, fio_dout, grant_err
  );

  // Fetch block side
  modport slave (
    input  pc_all, pc_valid, grant, flush, out_ready, fio_wen, fio_addr, fio_din,
    output in_ready, out_valid, out_warp, out_pc, out_instr, fio_dout, grant_err
  );
endinterface

// File: rtl/fetch_multiport.sv
// Multiport instruction fetch for the SIMT core. Each port turns a one-hot warp
// grant into a two-stage fetch (S1: PC/tag + synchronous IMEM read, S2: output
// register) with valid/ready back-pressure and per-warp flush.
// Optional feature macro: FETCH_GRANT_CHECK_EN (illegal-grant detection with a
// sticky grant_err flag; when undefined, lowest set grant bit wins and
// grant_err is tied low).
module fetch_multiport #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int IMEM_AW   = 10
) (
  input logic clk,
  input logic rst,
  fetch_multiport_if.slave bus
);
  localparam int MEM_WORDS = 1 << IMEM_AW;

  logic [31:0]          mem [MEM_WORDS];

  logic [NUM_PORTS-1:0] adv;
  logic [NUM_PORTS-1:0] take;
  logic [NUM_WARPS-1:0] g_slice [NUM_PORTS];
  logic [NUM_WARPS-1:0] sel_hot [NUM_PORTS];
  logic [ADDR_W-1:0]    sel_pc  [NUM_PORTS];
  logic [NUM_PORTS-1:0] sel_live;
  logic [NUM_PORTS-1:0] s1_hit;
  logic [NUM_PORTS-1:0] out_hit;

  logic [NUM_PORTS-1:0] s1_valid;
  logic [NUM_WARPS-1:0] s1_warp [NUM_PORTS];
  logic [ADDR_W-1:0]    s1_pc   [NUM_PORTS];
  logic [31:0]          rd_data [NUM_PORTS];

  logic [NUM_PORTS-1:0] out_valid_q;
  logic [NUM_WARPS-1:0] out_warp_q  [NUM_PORTS];
  logic [ADDR_W-1:0]    out_pc_q    [NUM_PORTS];
  logic [31:0]          out_instr_q [NUM_PORTS];
  logic [31:0]          fio_dout_q;

`ifdef FETCH_GRANT_CHECK_EN
  logic [NUM_PORTS-1:0] sel_multi;
  logic [NUM_PORTS-1:0] sel_pv;
  logic [NUM_PORTS-1:0] bad_grant;
  logic                 grant_err_q;
`endif

  // Per-port grant decode: pick the lowest granted warp, look up its PC and decide whether a fetch starts
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      adv[p]      = !out_valid_q[p] | bus.out_ready[p];
      g_slice[p]  = bus.grant[p*NUM_WARPS +: NUM_WARPS];
      sel_hot[p]  = g_slice[p] & (~g_slice[p] + NUM_WARPS'(1));
      sel_pc[p]   = '0;
      sel_live[p] = 1'b0;
`ifdef FETCH_GRANT_CHECK_EN
      sel_pv[p]    = 1'b0;
      sel_multi[p] = (g_slice[p] & (g_slice[p] - NUM_WARPS'(1))) != '0;
`endif
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (sel_hot[p][w]) begin
          sel_pc[p]   = bus.pc_all[w*ADDR_W +: ADDR_W];
          sel_live[p] = bus.pc_valid[w] & !bus.flush[w];
`ifdef FETCH_GRANT_CHECK_EN
          sel_pv[p]   = bus.pc_valid[w];
`endif
        end
      end
`ifdef FETCH_GRANT_CHECK_EN
      bad_grant[p] = (g_slice[p] != '0) & (sel_multi[p] | !sel_pv[p]);
      take[p]      = adv[p] & sel_live[p] & !sel_multi[p];
`else
      take[p]      = adv[p] & sel_live[p];
`endif
      s1_hit[p]  = |(s1_warp[p] & bus.flush);
      out_hit[p] = |(out_warp_q[p] & bus.flush);
    end
  end

  // Program-load write port; memory contents survive reset
  always_ff @(posedge clk) begin
    if (bus.fio_wen) mem[bus.fio_addr] <= bus.fio_din;
  end

  // Lane reads are only enabled while the port advances so a stalled S1 keeps its data
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (adv[p]) rd_data[p] <= mem[sel_pc[p][IMEM_AW+1:2]];
    end
  end

  // File-IO readback, one cycle latency, returns the pre-write word on a same-address write
  always_ff @(posedge clk) begin
    if (rst) fio_dout_q <= '0;
    else     fio_dout_q <= mem[bus.fio_addr];
  end

  // Two-stage pipeline per port: advance when the output slot frees up, otherwise hold; flush kills matching tags anywhere
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= '0;
      out_valid_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_warp[p]     <= '0;
        s1_pc[p]       <= '0;
        out_warp_q[p]  <= '0;
        out_pc_q[p]    <= '0;
        out_instr_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (adv[p]) begin
          s1_valid[p]    <= take[p];
          out_valid_q[p] <= s1_valid[p] & !s1_hit[p];
          if (take[p]) begin
            s1_warp[p] <= sel_hot[p];
            s1_pc[p]   <= sel_pc[p];
          end
          if (s1_valid[p] & !s1_hit[p]) begin
            out_warp_q[p]  <= s1_warp[p];
            out_pc_q[p]    <= s1_pc[p];
            out_instr_q[p] <= rd_data[p];
          end
        end else begin
          s1_valid[p]    <= s1_valid[p] & !s1_hit[p];
          out_valid_q[p] <= out_valid_q[p] & !out_hit[p];
        end
      end
    end
  end

`ifdef FETCH_GRANT_CHECK_EN
  // Sticky illegal-grant flag, raised only by grants a port actually accepts
  always_ff @(posedge clk) begin
    if (rst)                     grant_err_q <= 1'b0;
    else if (|(adv & bad_grant)) grant_err_q <= 1'b1;
  end
  assign bus.grant_err = grant_err_q;
`else
  assign bus.grant_err = 1'b0;
`endif

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.fio_dout  = fio_dout_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    assign bus.out_warp[p*NUM_WARPS +: NUM_WARPS] = out_warp_q[p];
    assign bus.out_pc[p*ADDR_W +: ADDR_W]         = out_pc_q[p];
    assign bus.out_instr[p*32 +: 32]              = out_instr_q[p];
  end
endmodule

// File: tb/tb_fetch_multiport.sv
// Self-checking bench for fetch_multiport: directed cycle table, hand-written
// corner sequences (read-first, reset mid-flight) and a randomized run against
// a queue-based reference model.
module tb_fetch_multiport;
  localparam int NW  = 8;
  localparam int NP  = 2;
  localparam int AW  = 32;
  localparam int MAW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_multiport_if #(.NUM_WARPS(NW), .NUM_PORTS(NP), .ADDR_W(AW), .IMEM_AW(MAW)) bus ();

  fetch_multiport #(.NUM_WARPS(NW), .NUM_PORTS(NP), .ADDR_W(AW), .IMEM_AW(MAW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] g0;
    logic [7:0] g1;
    logic [1:0] ordy;
    logic [7:0] fl;
    logic [7:0] pcv;
    logic [1:0] ir;
    logic [1:0] ov;
    logic [7:0] w0;
    logic [7:0] w1;
  } vec_t;

  typedef struct {
    int          w;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          shown;
  } entry_t;

  vec_t        vecs [$];
  entry_t      mq [NP][$];
  logic [31:0] model_mem [1024];
  logic [31:0] exp_fio;
  int          n_cmp;
  int          n_fail;

  function automatic logic [31:0] warp_pc(int w);
    if (w == 7) return 32'hF000_0028;
    return 32'h0000_000C + 32'(4 * w);
  endfunction

  function automatic logic [31:0] init_word(int a);
    if (a == 5) return 32'h8C22_0004;
    return 32'hA000_0000 | 32'(a);
  endfunction

  function automatic int low_idx(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // One comparison: counts it, reports a FAIL line on disagreement
  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(logic [7:0] g0, logic [7:0] g1, logic [1:0] ordy,
                                logic [7:0] fl, logic [7:0] pcv);
    bus.grant     = {g1, g0};
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.pc_valid  = pcv;
  endtask

  // Checks one port's output registers against a fetched warp from the fixed PC table
  task automatic check_lane(string tag, int p, logic [7:0] wexp);
    int w;
    logic [31:0] pc;
    w  = low_idx(wexp);
    pc = warp_pc(w);
    check_output({tag, " warp"},  bus.out_warp[p*NW +: NW], wexp);
    check_output({tag, " pc"},    bus.out_pc[p*AW +: AW], pc);
    check_output({tag, " instr"}, bus.out_instr[p*32 +: 32], model_mem[pc[11:2]]);
  endtask

  function automatic bit model_out_valid(int p);
    return mq[p].size() > 0 && mq[p][0].shown;
  endfunction

  // Reference model: advance each lane's in-flight list by one clock edge using current inputs
  task automatic model_edge();
    entry_t keep [$];
    entry_t e;
    logic [7:0] g;
    bit adv;
    int w;
    for (int p = 0; p < NP; p++) begin
      adv = !model_out_valid(p) || bus.out_ready[p];
      if (adv && model_out_valid(p)) void'(mq[p].pop_front());
      keep = {};
      for (int k = 0; k < mq[p].size(); k++)
        if (!bus.flush[mq[p][k].w]) keep.push_back(mq[p][k]);
      mq[p] = keep;
      if (adv) begin
        for (int k = 0; k < mq[p].size(); k++) mq[p][k].shown = 1'b1;
        g = bus.grant[p*NW +: NW];
        if (g != 8'h00) begin
          w = low_idx(g);
          if (bus.pc_valid[w] && !bus.flush[w]) begin
            e.w     = w;
            e.pc    = bus.pc_all[w*AW +: AW];
            e.instr = model_mem[e.pc[11:2]];
            e.shown = 1'b0;
            mq[p].push_back(e);
          end
        end
      end
    end
    exp_fio = model_mem[bus.fio_addr];
    if (bus.fio_wen) model_mem[bus.fio_addr] = bus.fio_din;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    apply_stimulus(8'h00, 8'h00, 2'b11, 8'h00, 8'hFF);
    bus.fio_wen  = 1'b0;
    bus.fio_addr = '0;
    bus.fio_din  = '0;
    for (int w = 0; w < NW; w++) bus.pc_all[w*AW +: AW] = warp_pc(w);
    for (int a = 0; a < 1024; a++) model_mem[a] = 32'h0;
    for (int a = 0; a < 16; a++) model_mem[a] = init_word(a);

    // Reset state
    @(posedge clk); #1;
    check_output("rst out_valid", bus.out_valid, 2'b00);
    check_output("rst out_pc", bus.out_pc, 64'h0);
    check_output("rst out_warp", bus.out_warp, 16'h0);
    check_output("rst out_instr", bus.out_instr, 64'h0);
    check_output("rst fio_dout", bus.fio_dout, 32'h0);
    check_output("rst grant_err", bus.grant_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("post-rst in_ready", bus.in_ready, 2'b11);

    // Program load
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      bus.fio_wen  = 1'b1;
      bus.fio_addr = 10'(a);
      bus.fio_din  = model_mem[a];
      @(negedge clk);
    end
    bus.fio_wen = 1'b0;
    @(negedge clk);

    // Directed cycle table: {g0, g1, out_ready, flush, pc_valid} -> {in_ready, out_valid, warp0, warp1}
    vecs.push_back(vec_t'{8'h04, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b01, 8'h04, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h03, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b01, 8'h01, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h01, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h02, 2'b01, 8'h00, 8'hFF, 2'b11, 2'b10, 8'h00, 8'h01});
    vecs.push_back(vec_t'{8'h00, 8'h04, 2'b01, 8'h00, 8'hFF, 2'b01, 2'b10, 8'h00, 8'h01});
    vecs.push_back(vec_t'{8'h00, 8'h08, 2'b01, 8'h00, 8'hFF, 2'b01, 2'b10, 8'h00, 8'h01});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b01, 8'h00, 8'hFF, 2'b01, 2'b10, 8'h00, 8'h01});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b10, 8'h00, 8'h02});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h20, 8'h00, 2'b10, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h08, 8'h00, 2'b10, 8'h00, 8'hFF, 2'b11, 2'b01, 8'h20, 8'h00});
    vecs.push_back(vec_t'{8'h40, 8'h00, 2'b10, 8'h08, 8'hFF, 2'b10, 2'b01, 8'h20, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h10, 8'h10, 2'b11, 8'h10, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h80, 8'h40, 2'b11, 8'h00, 8'h7F, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b10, 8'h00, 8'h40});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h80, 8'h80, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b11, 8'h80, 8'h80});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h02, 8'h00, 2'b10, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b10, 8'h00, 8'hFF, 2'b11, 2'b01, 8'h02, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b10, 8'h02, 8'hFF, 2'b10, 2'b00, 8'h00, 8'h00});
    vecs.push_back(vec_t'{8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 2'b00, 8'h00, 8'h00});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].g0, vecs[i].g1, vecs[i].ordy, vecs[i].fl, vecs[i].pcv);
      #1;
      check_output($sformatf("v%0d in_ready", i), bus.in_ready, vecs[i].ir);
      @(posedge clk); #1;
      check_output($sformatf("v%0d out_valid", i), bus.out_valid, vecs[i].ov);
      check_output($sformatf("v%0d grant_err", i), bus.grant_err, 1'b0);
      if (vecs[i].ov[0]) check_lane($sformatf("v%0d p0", i), 0, vecs[i].w0);
      if (vecs[i].ov[1]) check_lane($sformatf("v%0d p1", i), 1, vecs[i].w1);
      @(negedge clk);
    end

    // Read-first: port1 fetches addr 7 in the same cycle fio overwrites it, then re-fetches
    apply_stimulus(8'h00, 8'h10, 2'b11, 8'h00, 8'hFF);
    bus.fio_wen  = 1'b1;
    bus.fio_addr = 10'd7;
    bus.fio_din  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_output("rf fio_dout old", bus.fio_dout, 32'hA000_0007);
    @(negedge clk);
    bus.fio_wen = 1'b0;
    @(posedge clk); #1;
    check_output("rf p1 valid old", bus.out_valid[1], 1'b1);
    check_output("rf p1 instr old", bus.out_instr[63:32], 32'hA000_0007);
    check_output("rf fio_dout new", bus.fio_dout, 32'hDEAD_BEEF);
    @(negedge clk);
    apply_stimulus(8'h00, 8'h00, 2'b11, 8'h00, 8'hFF);
    @(posedge clk); #1;
    check_output("rf p1 valid new", bus.out_valid[1], 1'b1);
    check_output("rf p1 instr new", bus.out_instr[63:32], 32'hDEAD_BEEF);
    model_mem[7] = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);

    // Reset while both S1 stages hold live fetches
    apply_stimulus(8'h01, 8'h02, 2'b11, 8'h00, 8'hFF);
    @(negedge clk);
    apply_stimulus(8'h04, 8'h08, 2'b11, 8'h00, 8'hFF);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("mid-rst out_valid", bus.out_valid, 2'b00);
    check_output("mid-rst out_pc", bus.out_pc, 64'h0);
    check_output("mid-rst fio_dout", bus.fio_dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(8'h00, 8'h00, 2'b11, 8'h00, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_output($sformatf("post-rst%0d out_valid", c), bus.out_valid, 2'b00);
      @(negedge clk);
    end

    // Randomized run against the reference model
    exp_fio = 32'h0;
    for (int c = 0; c < 600; c++) begin
      logic [7:0] g [NP];
      logic [1:0] ordy;
      logic [1:0] exp_ir;
      int a;
      int b;
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 9))
          0, 1:    g[p] = 8'h00;
          2: begin
            a    = $urandom_range(0, 7);
            b    = (a + 1 + $urandom_range(0, 6)) % 8;
            g[p] = 8'($urandom) | (8'h01 << a) | (8'h01 << b);
          end
          default: g[p] = 8'h01 << $urandom_range(0, 7);
        endcase
        ordy[p] = ($urandom_range(0, 3) != 0);
      end
      apply_stimulus(g[0], g[1], ordy,
                     ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00,
                     ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF);
      for (int w = 0; w < NW; w++) bus.pc_all[w*AW +: AW] = rand_pc();
      bus.fio_wen  = ($urandom_range(0, 7) == 0);
      bus.fio_addr = 10'($urandom_range(0, 15));
      bus.fio_din  = $urandom;
      #1;
      for (int p = 0; p < NP; p++) exp_ir[p] = !model_out_valid(p) || ordy[p];
      check_output($sformatf("r%0d in_ready", c), bus.in_ready, exp_ir);
      @(posedge clk);
      model_edge();
      #1;
      for (int p = 0; p < NP; p++) begin
        check_output($sformatf("r%0d p%0d out_valid", c, p), bus.out_valid[p], model_out_valid(p));
        if (model_out_valid(p)) begin
          check_output($sformatf("r%0d p%0d warp", c, p), bus.out_warp[p*NW +: NW], 8'h01 << mq[p][0].w);
          check_output($sformatf("r%0d p%0d pc", c, p), bus.out_pc[p*AW +: AW], mq[p][0].pc);
          check_output($sformatf("r%0d p%0d instr", c, p), bus.out_instr[p*32 +: 32], mq[p][0].instr);
        end
      end
      check_output($sformatf("r%0d fio_dout", c), bus.fio_dout, exp_fio);
      check_output($sformatf("r%0d grant_err", c), bus.grant_err, 1'b0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
